// File: rtl/mem_miss_arbiter.sv
// Arbitrates icache and dcache miss traffic onto one memory port, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise dcache wins ties.
module mem_miss_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int LINE_W         = 128,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ic_req_valid,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_req_ready,
  output logic              ic_rsp_valid,
  output logic [LINE_W-1:0] ic_rsp_data,
  input  logic              dc_req_valid,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic              dc_req_is_store,
  input  logic [LINE_W-1:0] dc_req_data,
  output logic              dc_req_ready,
  output logic              dc_rsp_valid,
  output logic [LINE_W-1:0] dc_rsp_data,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_is_store,
  output logic [LINE_W-1:0] mem_req_data,
  input  logic              mem_rsp_valid,
  input  logic [LINE_W-1:0] mem_rsp_data,
  output logic              busy,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic              owner_dc_reg;
  logic              last_grant_dc_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              is_store_reg;
  logic [LINE_W-1:0] data_reg;
  logic              ic_rsp_valid_reg, dc_rsp_valid_reg;
  logic [LINE_W-1:0] ic_rsp_data_reg, dc_rsp_data_reg;
  logic              timeout_err_reg;

  logic any_req;
  logic tie_pick_dc;
  logic grant_dc;
  logic rsp_done;
  logic timeout_hit;

`ifdef ARB_ROUND_ROBIN_EN
  assign tie_pick_dc = ~last_grant_dc_reg;
`else
  logic unused_last_grant;
  assign tie_pick_dc       = 1'b1;
  assign unused_last_grant = last_grant_dc_reg;
`endif

  assign any_req     = ic_req_valid | dc_req_valid;
  assign grant_dc    = dc_req_valid & (~ic_req_valid | tie_pick_dc);
  assign rsp_done    = (state_reg == WAIT_RSP) & mem_rsp_valid;
  // A response in the final watchdog cycle wins over the timeout.
  assign timeout_hit = (state_reg == WAIT_RSP) & ~mem_rsp_valid & (cnt_reg == CNT_LAST);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (any_req) state_next = ISSUE;
      ISSUE:    state_next = WAIT_RSP;
      WAIT_RSP: if (rsp_done || timeout_hit) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg         <= IDLE;
      cnt_reg           <= '0;
      owner_dc_reg      <= 1'b0;
      last_grant_dc_reg <= 1'b0;
      addr_reg          <= '0;
      is_store_reg      <= 1'b0;
      data_reg          <= '0;
      ic_rsp_valid_reg  <= 1'b0;
      dc_rsp_valid_reg  <= 1'b0;
      ic_rsp_data_reg   <= '0;
      dc_rsp_data_reg   <= '0;
      timeout_err_reg   <= 1'b0;
    end else begin
      state_reg        <= state_next;
      ic_rsp_valid_reg <= 1'b0;
      dc_rsp_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            owner_dc_reg      <= grant_dc;
            last_grant_dc_reg <= grant_dc;
            addr_reg          <= grant_dc ? dc_req_addr : ic_req_addr;
            is_store_reg      <= grant_dc & dc_req_is_store;
            data_reg          <= grant_dc ? dc_req_data : '0;
          end
        end
        ISSUE: cnt_reg <= '0;
        WAIT_RSP: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (rsp_done || timeout_hit) begin
            if (owner_dc_reg) begin
              dc_rsp_valid_reg <= 1'b1;
              dc_rsp_data_reg  <= rsp_done ? mem_rsp_data : '0;
            end else begin
              ic_rsp_valid_reg <= 1'b1;
              ic_rsp_data_reg  <= rsp_done ? mem_rsp_data : '0;
            end
          end
          if (timeout_hit) timeout_err_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mem_req_valid    = (state_reg == ISSUE);
  assign ic_req_ready     = (state_reg == ISSUE) & ~owner_dc_reg;
  assign dc_req_ready     = (state_reg == ISSUE) & owner_dc_reg;
  assign mem_req_addr     = addr_reg;
  assign mem_req_is_store = is_store_reg;
  assign mem_req_data     = data_reg;
  assign ic_rsp_valid     = ic_rsp_valid_reg;
  assign ic_rsp_data      = ic_rsp_data_reg;
  assign dc_rsp_valid     = dc_rsp_valid_reg;
  assign dc_rsp_data      = dc_rsp_data_reg;
  assign busy             = (state_reg != IDLE);
  assign timeout_err      = timeout_err_reg;

endmodule

// File: tb/tb_mem_miss_arbiter.sv
// Self-checking bench for mem_miss_arbiter: directed table, corner sequences, random transactions.
// Expectations follow ARB_ROUND_ROBIN_EN when it is defined.
module tb_mem_miss_arbiter;

  localparam int T = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         ic_req_valid;
  logic [31:0]  ic_req_addr;
  logic         ic_req_ready;
  logic         ic_rsp_valid;
  logic [127:0] ic_rsp_data;
  logic         dc_req_valid;
  logic [31:0]  dc_req_addr;
  logic         dc_req_is_store;
  logic [127:0] dc_req_data;
  logic         dc_req_ready;
  logic         dc_rsp_valid;
  logic [127:0] dc_rsp_data;
  logic         mem_req_valid;
  logic [31:0]  mem_req_addr;
  logic         mem_req_is_store;
  logic [127:0] mem_req_data;
  logic         mem_rsp_valid;
  logic [127:0] mem_rsp_data;
  logic         busy;
  logic         timeout_err;

  mem_miss_arbiter #(.ADDR_W(32), .LINE_W(128), .TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
    .ic_rsp_valid(ic_rsp_valid), .ic_rsp_data(ic_rsp_data),
    .dc_req_valid(dc_req_valid), .dc_req_addr(dc_req_addr), .dc_req_is_store(dc_req_is_store),
    .dc_req_data(dc_req_data), .dc_req_ready(dc_req_ready),
    .dc_rsp_valid(dc_rsp_valid), .dc_rsp_data(dc_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_is_store(mem_req_is_store), .mem_req_data(mem_req_data),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_fail = 0;

  // Bench-side view of what each cache last received.
  logic [127:0] exp_ic_data;
  logic [127:0] exp_dc_data;
  logic         model_last_dc;
  logic         model_err;

  typedef struct packed {
    logic         ic_v;
    logic         dc_v;
    logic [31:0]  ic_a;
    logic [31:0]  dc_a;
    logic         dc_st;
    logic [127:0] dc_d;
    logic [7:0]   rsp_k;   // WAIT_RSP cycle carrying the response, 0 = none
    logic [127:0] rsp_d;
    logic         exp_dc;
    logic [31:0]  exp_a;
    logic         exp_st;
    logic [127:0] exp_d;
    logic         exp_err;
  } vec_t;

  vec_t tbl [9];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_mem_valid"}, mem_req_valid, 0);
    chk({tag, "_mem_addr"}, mem_req_addr, 0);
    chk({tag, "_mem_store"}, mem_req_is_store, 0);
    chk({tag, "_mem_data"}, mem_req_data, 0);
    chk({tag, "_ic_ready"}, ic_req_ready, 0);
    chk({tag, "_dc_ready"}, dc_req_ready, 0);
    chk({tag, "_ic_rsp_valid"}, ic_rsp_valid, 0);
    chk({tag, "_dc_rsp_valid"}, dc_rsp_valid, 0);
    chk({tag, "_ic_rsp_data"}, ic_rsp_data, 0);
    chk({tag, "_dc_rsp_data"}, dc_rsp_data, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  // One full transaction starting from IDLE; leaves the DUT in the response cycle
  // when keep_loser is set, otherwise one cycle later.
  task automatic do_txn(input logic ic_v, input logic dc_v,
                        input logic [31:0] ic_a, input logic [31:0] dc_a,
                        input logic dc_st, input logic [127:0] dc_d,
                        input int rsp_k, input logic [127:0] rsp_d,
                        input logic exp_dc, input logic [31:0] exp_a,
                        input logic exp_st, input logic [127:0] exp_d,
                        input logic exp_err, input logic keep_loser);
    int j;
    bit done;
    bit timed_out;
    ic_req_valid = ic_v; ic_req_addr = ic_a;
    dc_req_valid = dc_v; dc_req_addr = dc_a; dc_req_is_store = dc_st; dc_req_data = dc_d;
    mem_rsp_valid = 1'b0;
    step();
    chk("issue_mem_valid", mem_req_valid, 1);
    chk("issue_ic_ready", ic_req_ready, !exp_dc);
    chk("issue_dc_ready", dc_req_ready, exp_dc);
    chk("issue_addr", mem_req_addr, exp_a);
    chk("issue_store", mem_req_is_store, exp_st);
    chk("issue_data", mem_req_data, exp_d);
    chk("issue_busy", busy, 1);
    if (exp_dc) dc_req_valid = 1'b0; else ic_req_valid = 1'b0;
    if (!keep_loser) begin ic_req_valid = 1'b0; dc_req_valid = 1'b0; end
    mem_rsp_valid = 1'b1;       // must be ignored while issuing
    mem_rsp_data  = ~rsp_d;
    step();
    mem_rsp_valid = 1'b0;
    chk("wait_mem_valid", mem_req_valid, 0);
    chk("wait_ic_ready", ic_req_ready, 0);
    chk("wait_dc_ready", dc_req_ready, 0);
    chk("wait_addr_hold", mem_req_addr, exp_a);
    chk("wait_busy", busy, 1);
    chk("wait_no_rsp", {ic_rsp_valid, dc_rsp_valid}, 0);
    j = 1;
    done = 0;
    while (!done) begin
      mem_rsp_valid = (j == rsp_k);
      mem_rsp_data  = rsp_d;
      step();
      done = (j == rsp_k) || (j == T);
      if (!done) begin
        chk("wait_quiet_rsp", {ic_rsp_valid, dc_rsp_valid}, 0);
        chk("wait_quiet_busy", busy, 1);
      end
      j++;
    end
    mem_rsp_valid = 1'b0;
    timed_out = !(rsp_k >= 1 && rsp_k <= T);
    if (exp_dc) exp_dc_data = timed_out ? 128'h0 : rsp_d;
    else        exp_ic_data = timed_out ? 128'h0 : rsp_d;
    chk("rsp_ic_valid", ic_rsp_valid, !exp_dc);
    chk("rsp_dc_valid", dc_rsp_valid, exp_dc);
    chk("rsp_ic_data", ic_rsp_data, exp_ic_data);
    chk("rsp_dc_data", dc_rsp_data, exp_dc_data);
    chk("rsp_busy", busy, 0);
    chk("rsp_timeout_err", timeout_err, exp_err);
    if (!keep_loser) begin
      step();
      chk("post_rsp_pulse", {ic_rsp_valid, dc_rsp_valid}, 0);
      chk("post_rsp_busy", busy, 0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [2:0]   tie_exp_dc;
    int           sel, rk, gap;
    logic         ic_v, dc_v, dc_st, tie_pick, exp_dc;
    logic [31:0]  ic_a, dc_a;
    logic [127:0] dc_d, rsp_d;

    // Table rows assume last grant = DC when the table starts.
    tbl[0] = '{1'b1, 1'b0, 32'h0000_1000, 32'h0, 1'b0, 128'h0, 8'd3, {16{8'hA5}},
               1'b0, 32'h0000_1000, 1'b0, 128'h0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 32'h0, 32'h0000_2040, 1'b1, 128'h1234, 8'd1, 128'h0,
               1'b1, 32'h0000_2040, 1'b1, 128'h1234, 1'b0};
`ifdef ARB_ROUND_ROBIN_EN
    tbl[2] = '{1'b1, 1'b1, 32'h3000, 32'h4000, 1'b0, 128'h77, 8'd2, {16{8'hC3}},
               1'b0, 32'h3000, 1'b0, 128'h0, 1'b0};
`else
    tbl[2] = '{1'b1, 1'b1, 32'h3000, 32'h4000, 1'b0, 128'h77, 8'd2, {16{8'hC3}},
               1'b1, 32'h4000, 1'b0, 128'h77, 1'b0};
`endif
    tbl[3] = '{1'b1, 1'b1, 32'h3100, 32'h4100, 1'b1, 128'hBEEF, 8'd4, 128'h0DD,
               1'b1, 32'h4100, 1'b1, 128'hBEEF, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 32'h5000, 32'h5555, 1'b1, {128{1'b1}}, 8'd8, {16{8'h5A}},
               1'b0, 32'h5000, 1'b0, 128'h0, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 32'h6100, 32'h6000, 1'b0, 128'h99, 8'd1, 128'h6666,
               1'b1, 32'h6000, 1'b0, 128'h99, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 32'h7000, 32'h0, 1'b0, 128'h0, 8'd0, 128'h7777,
               1'b0, 32'h7000, 1'b0, 128'h0, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 32'h0, 32'h8000, 1'b0, 128'h0, 8'd5, {8{16'h1111}},
               1'b1, 32'h8000, 1'b0, 128'h0, 1'b1};
`ifdef ARB_ROUND_ROBIN_EN
    tbl[8] = '{1'b1, 1'b1, 32'h9000, 32'h9100, 1'b1, 128'h42, 8'd9, 128'h9999,
               1'b0, 32'h9000, 1'b0, 128'h0, 1'b1};
    tie_exp_dc = 3'b101;
`else
    tbl[8] = '{1'b1, 1'b1, 32'h9000, 32'h9100, 1'b1, 128'h42, 8'd9, 128'h9999,
               1'b1, 32'h9100, 1'b1, 128'h42, 1'b1};
    tie_exp_dc = 3'b111;
`endif

    reset = 1'b0;
    ic_req_valid = 0; ic_req_addr = 0;
    dc_req_valid = 0; dc_req_addr = 0; dc_req_is_store = 0; dc_req_data = 0;
    mem_rsp_valid = 0; mem_rsp_data = 0;
    exp_ic_data = 0; exp_dc_data = 0; model_last_dc = 0; model_err = 0;
    repeat (2) @(posedge clock);
    #1;
    chk_all_zero("reset");
    reset = 1'b1;
    step();

    // Spurious memory response while idle.
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = {4{32'hDEAD_BEEF}};
    for (int i = 0; i < 3; i++) begin
      if (i == 2) mem_rsp_valid = 1'b0;
      step();
      chk("spurious_rsp_valid", {ic_rsp_valid, dc_rsp_valid}, 0);
      chk("spurious_busy", busy, 0);
      chk("spurious_mem_valid", mem_req_valid, 0);
    end

    // Three rounds of simultaneous requests, loser holds its request.
    for (int r = 0; r < 3; r++) begin
      do_txn(1'b1, 1'b1, 32'hA000 + r, 32'hB000 + r, 1'b0, 128'h5 + r, 2, 128'hF0 + r,
             tie_exp_dc[r], tie_exp_dc[r] ? 32'hB000 + r : 32'hA000 + r,
             1'b0, tie_exp_dc[r] ? 128'h5 + r : 128'h0, 1'b0, 1'b1);
    end
    ic_req_valid = 1'b0;
    dc_req_valid = 1'b0;
    step();
    chk("ties_end_rsp", {ic_rsp_valid, dc_rsp_valid}, 0);
    chk("ties_end_busy", busy, 0);

    for (int i = 0; i < 9; i++) begin
      do_txn(tbl[i].ic_v, tbl[i].dc_v, tbl[i].ic_a, tbl[i].dc_a, tbl[i].dc_st, tbl[i].dc_d,
             int'(tbl[i].rsp_k), tbl[i].rsp_d, tbl[i].exp_dc, tbl[i].exp_a, tbl[i].exp_st,
             tbl[i].exp_d, tbl[i].exp_err, 1'b0);
    end

    // Asynchronous reset in the middle of WAIT_RSP.
    ic_req_valid = 1'b1; ic_req_addr = 32'hDEAD_0000;
    step();
    ic_req_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
    mem_rsp_valid = 1'b1;
    #1;
    chk_all_zero("async_reset");
    exp_ic_data = 0; exp_dc_data = 0; model_last_dc = 0; model_err = 0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    step();
    mem_rsp_valid = 1'b0;
    chk("after_reset_rsp", {ic_rsp_valid, dc_rsp_valid}, 0);
    chk("after_reset_busy", busy, 0);
    step();
    chk("after_reset_rsp2", {ic_rsp_valid, dc_rsp_valid}, 0);

    // Random transactions against the arbitration/watchdog rules.
    for (int n = 0; n < 40; n++) begin
      sel   = $urandom_range(1, 3);
      ic_v  = sel[0];
      dc_v  = sel[1];
      ic_a  = $urandom;
      dc_a  = $urandom;
      dc_st = 1'($urandom_range(0, 1));
      dc_d  = {$urandom, $urandom, $urandom, $urandom};
      rsp_d = {$urandom, $urandom, $urandom, $urandom};
      rk    = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 10));
`ifdef ARB_ROUND_ROBIN_EN
      tie_pick = !model_last_dc;
`else
      tie_pick = 1'b1;
`endif
      exp_dc = dc_v && (!ic_v || tie_pick);
      model_last_dc = exp_dc;
      model_err = model_err || (rk == 0) || (rk > T);
      do_txn(ic_v, dc_v, ic_a, dc_a, dc_st, dc_d, rk, rsp_d, exp_dc,
             exp_dc ? dc_a : ic_a, exp_dc && dc_st, exp_dc ? dc_d : 128'h0,
             model_err, 1'b0);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        mem_rsp_valid = 1'($urandom_range(0, 1));
        mem_rsp_data  = {$urandom, $urandom, $urandom, $urandom};
        step();
        chk("rand_idle_rsp", {ic_rsp_valid, dc_rsp_valid}, 0);
        chk("rand_idle_busy", busy, 0);
      end
      mem_rsp_valid = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
